// File: rtl/regfile_pkg.sv
// Shared widths and types for the tagged integer register file.
// Default configuration: 32 x 32-bit registers, 4-bit ROB tags, 2 read ports.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = $clog2(NREG);
    localparam int TAG_W      = 4;
    localparam int NRD        = 2;

    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [TAG_W-1:0]      rob_tag_t;
    typedef logic [XLEN-1:0]       word_t;

endpackage

// File: rtl/regfile_tagged_rdport.sv
// One combinational read port: x0 override, busy/tag selection and optional
// commit-to-read bypass (enabled by REGFILE_TAGGED_BYPASS_EN).
module regfile_tagged_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int TAG_W = regfile_pkg::TAG_W,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                       rst_in,
    input  logic [AW-1:0]              addr_in,
    input  logic [NREG-1:0][XLEN-1:0]  data_arr_in,
    input  logic [NREG-1:0]            busy_arr_in,
    input  logic [NREG-1:0][TAG_W-1:0] tag_arr_in,
    input  logic                       cmt_we_in,
    input  logic [AW-1:0]              cmt_addr_in,
    input  logic [TAG_W-1:0]           cmt_tag_in,
    input  logic [XLEN-1:0]            cmt_data_in,
    output logic [XLEN-1:0]            data_out,
    output logic                       busy_out,
    output logic [TAG_W-1:0]           tag_out
);

    logic bypass_hit;

`ifdef REGFILE_TAGGED_BYPASS_EN
    // Only a commit that would actually retire this rename may forward its value.
    assign bypass_hit = cmt_we_in && (cmt_addr_in == addr_in) && busy_arr_in[addr_in]
                        && (tag_arr_in[addr_in] == cmt_tag_in);
`else
    logic unused_cmt;
    assign unused_cmt = ^{cmt_we_in, cmt_addr_in, cmt_tag_in, cmt_data_in};
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        data_out = '0;
        busy_out = 1'b0;
        tag_out  = '0;
        if (rst_in && (addr_in != '0)) begin
            if (bypass_hit) begin
                data_out = cmt_data_in;
            end else begin
                data_out = data_arr_in[addr_in];
                if (busy_arr_in[addr_in]) begin
                    busy_out = 1'b1;
                    tag_out  = tag_arr_in[addr_in];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_tagged.sv
// Integer register file with per-register rename state (busy + ROB tag).
// Optional commit-to-read bypass is selected with REGFILE_TAGGED_BYPASS_EN.
module regfile_tagged
    import regfile_pkg::*;
#(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREG  = regfile_pkg::NREG,
    parameter int TAG_W = regfile_pkg::TAG_W,
    parameter int NRD   = regfile_pkg::NRD,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [NRD*AW-1:0]     rd_addr_in,
    output logic [NRD*XLEN-1:0]   rd_data_out,
    output logic [NRD-1:0]        rd_busy_out,
    output logic [NRD*TAG_W-1:0]  rd_tag_out,
    input  logic                  disp_we_in,
    input  logic [AW-1:0]         disp_addr_in,
    input  logic [TAG_W-1:0]      disp_tag_in,
    input  logic                  cmt_we_in,
    input  logic [AW-1:0]         cmt_addr_in,
    input  logic [TAG_W-1:0]      cmt_tag_in,
    input  logic [XLEN-1:0]       cmt_data_in,
    input  logic                  flush_in
);

    logic [NREG-1:0][XLEN-1:0]  data_q;
    logic [NREG-1:0]            busy_q;
    logic [NREG-1:0][TAG_W-1:0] tag_q;

    // Register 0 is never written outside reset, so it stays zero.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (cmt_we_in && (cmt_addr_in == AW'(i))) begin
                    data_q[i] <= cmt_data_in;
                end
                // Priority: flush drops everything, a new rename beats the retiring one.
                if (flush_in) begin
                    busy_q[i] <= 1'b0;
                end else if (disp_we_in && (disp_addr_in == AW'(i))) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= disp_tag_in;
                end else if (cmt_we_in && (cmt_addr_in == AW'(i)) && busy_q[i]
                             && (tag_q[i] == cmt_tag_in)) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rdport
        regfile_tagged_rdport #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .AW    (AW)
        ) u_rdport (
            .rst_in      (rst_in),
            .addr_in     (rd_addr_in[k*AW +: AW]),
            .data_arr_in (data_q),
            .busy_arr_in (busy_q),
            .tag_arr_in  (tag_q),
            .cmt_we_in   (cmt_we_in),
            .cmt_addr_in (cmt_addr_in),
            .cmt_tag_in  (cmt_tag_in),
            .cmt_data_in (cmt_data_in),
            .data_out    (rd_data_out[k*XLEN +: XLEN]),
            .busy_out    (rd_busy_out[k]),
            .tag_out     (rd_tag_out[k*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Self-checking bench for regfile_tagged: table-driven rows plus hand-written
// sequences for bypass, x0 writes and mid-rename reset.
module tb_regfile_tagged;
    import regfile_pkg::*;

    localparam int AW = REG_ADDR_W;
    localparam int EW = XLEN + 1 + TAG_W;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NRD*AW-1:0]    rd_addr_in;
    logic [NRD*XLEN-1:0]  rd_data_out;
    logic [NRD-1:0]       rd_busy_out;
    logic [NRD*TAG_W-1:0] rd_tag_out;
    logic                 disp_we_in;
    logic [AW-1:0]        disp_addr_in;
    logic [TAG_W-1:0]     disp_tag_in;
    logic                 cmt_we_in;
    logic [AW-1:0]        cmt_addr_in;
    logic [TAG_W-1:0]     cmt_tag_in;
    logic [XLEN-1:0]      cmt_data_in;
    logic                 flush_in;

    regfile_tagged dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rd_addr_in   (rd_addr_in),
        .rd_data_out  (rd_data_out),
        .rd_busy_out  (rd_busy_out),
        .rd_tag_out   (rd_tag_out),
        .disp_we_in   (disp_we_in),
        .disp_addr_in (disp_addr_in),
        .disp_tag_in  (disp_tag_in),
        .cmt_we_in    (cmt_we_in),
        .cmt_addr_in  (cmt_addr_in),
        .cmt_tag_in   (cmt_tag_in),
        .cmt_data_in  (cmt_data_in),
        .flush_in     (flush_in)
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct {
        logic             disp_we;
        logic [AW-1:0]    disp_addr;
        logic [TAG_W-1:0] disp_tag;
        logic             cmt_we;
        logic [AW-1:0]    cmt_addr;
        logic [TAG_W-1:0] cmt_tag;
        logic [XLEN-1:0]  cmt_data;
        logic             flush;
        logic [AW-1:0]    rd_addr;
        logic [XLEN-1:0]  exp_data;
        logic             exp_busy;
        logic [TAG_W-1:0] exp_tag;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic dw, input int da, input int dt,
                                input logic cw, input int ca, input int ct,
                                input logic [XLEN-1:0] cd, input logic fl,
                                input int ra, input logic [XLEN-1:0] ed,
                                input logic eb, input int et);
        vec_t v;
        v.disp_we = dw; v.disp_addr = AW'(da); v.disp_tag = TAG_W'(dt);
        v.cmt_we = cw; v.cmt_addr = AW'(ca); v.cmt_tag = TAG_W'(ct); v.cmt_data = cd;
        v.flush = fl; v.rd_addr = AW'(ra);
        v.exp_data = ed; v.exp_busy = eb; v.exp_tag = TAG_W'(et);
        return v;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_we_in = 1'b0; disp_addr_in = '0; disp_tag_in = '0;
        cmt_we_in = 1'b0; cmt_addr_in = '0; cmt_tag_in = '0; cmt_data_in = '0;
        flush_in = 1'b0;
    endtask

    task automatic drive_disp(input int a, input int t);
        disp_we_in = 1'b1; disp_addr_in = AW'(a); disp_tag_in = TAG_W'(t);
    endtask

    task automatic drive_cmt(input int a, input int t, input logic [XLEN-1:0] d);
        cmt_we_in = 1'b1; cmt_addr_in = AW'(a); cmt_tag_in = TAG_W'(t); cmt_data_in = d;
    endtask

    // Drive both read ports, queue expectations, then compare after settling.
    task automatic rd_check(input string name, input int a0, input int a1,
                            input logic [EW-1:0] e0, input logic [EW-1:0] e1);
        logic [EW-1:0] act;
        logic [EW-1:0] exp_v;
        rd_addr_in = {AW'(a1), AW'(a0)};
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        #1;
        for (int k = 0; k < NRD; k++) begin
            act   = {rd_data_out[k*XLEN +: XLEN], rd_busy_out[k], rd_tag_out[k*TAG_W +: TAG_W]};
            exp_v = exp_q.pop_front();
            n_compared++;
            if (act !== exp_v) begin
                n_mismatched++;
                $display("FAIL %s port%0d: got data=%h busy=%b tag=%0d, want data=%h busy=%b tag=%0d",
                         name, k, act[EW-1 -: XLEN], act[TAG_W], act[TAG_W-1:0],
                         exp_v[EW-1 -: XLEN], exp_v[TAG_W], exp_v[TAG_W-1:0]);
            end
        end
    endtask

    function automatic logic [EW-1:0] ex(input logic [XLEN-1:0] d, input logic b, input int t);
        return {d, b, TAG_W'(t)};
    endfunction

    initial begin
        idle();
        rd_addr_in = '0;
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;

        // 1: everything reads zero after reset
        for (int i = 0; i < NREG; i++) begin
            rd_check("reset_read", i, NREG - 1 - i, ex(0, 0, 0), ex(0, 0, 0));
        end

        // 2-4: rename, tag precedence, same-cycle events (reads see pre-edge state)
        vecs[0]  = mk(1, 5, 3,  0, 0, 0, 32'h0,        0, 5, 32'h0,        0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 32'h0,        1, 3);
        vecs[2]  = mk(0, 0, 0,  1, 5, 3, 32'hDEADBEEF, 0, 6, 32'h0,        0, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 0, 0);
        vecs[4]  = mk(1, 7, 2,  0, 0, 0, 32'h0,        0, 7, 32'h0,        0, 0);
        vecs[5]  = mk(1, 7, 9,  0, 0, 0, 32'h0,        0, 7, 32'h0,        1, 2);
        vecs[6]  = mk(0, 0, 0,  1, 7, 2, 32'h11,       0, 7, 32'h0,        1, 9);
        vecs[7]  = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 7, 32'h11,       1, 9);
        vecs[8]  = mk(0, 0, 0,  1, 7, 9, 32'h22,       0, 5, 32'hDEADBEEF, 0, 0);
        vecs[9]  = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 7, 32'h22,       0, 0);
        vecs[10] = mk(1, 4, 1,  0, 0, 0, 32'h0,        0, 4, 32'h0,        0, 0);
        vecs[11] = mk(1, 4, 6,  1, 4, 1, 32'h55,       0, 7, 32'h22,       0, 0);
        vecs[12] = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 4, 32'h55,       1, 6);
        vecs[13] = mk(1, 9, 1,  0, 0, 0, 32'h0,        1, 4, 32'h55,       1, 6);
        vecs[14] = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 9, 32'h0,        0, 0);
        vecs[15] = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 4, 32'h55,       0, 0);
        vecs[16] = mk(1, 8, 7,  0, 0, 0, 32'h0,        0, 8, 32'h0,        0, 0);
        vecs[17] = mk(0, 0, 0,  1, 8, 7, 32'h77,       1, 3, 32'h0,        0, 0);
        vecs[18] = mk(0, 0, 0,  0, 0, 0, 32'h0,        0, 8, 32'h77,       0, 0);

        for (int r = 0; r < 19; r++) begin
            idle();
            if (vecs[r].disp_we) drive_disp(int'(vecs[r].disp_addr), int'(vecs[r].disp_tag));
            if (vecs[r].cmt_we)  drive_cmt(int'(vecs[r].cmt_addr), int'(vecs[r].cmt_tag), vecs[r].cmt_data);
            flush_in = vecs[r].flush;
            rd_check($sformatf("vec%0d", r), int'(vecs[r].rd_addr), int'(vecs[r].rd_addr),
                     ex(vecs[r].exp_data, vecs[r].exp_busy, int'(vecs[r].exp_tag)),
                     ex(vecs[r].exp_data, vecs[r].exp_busy, int'(vecs[r].exp_tag)));
            tick();
        end
        idle();

        // 5: commit-cycle read of a busy register
        drive_disp(3, 4);
        tick();
        idle();
        drive_cmt(3, 4, 32'hABCD);
`ifdef REGFILE_TAGGED_BYPASS_EN
        rd_check("bypass_same_cycle", 3, 3, ex(32'hABCD, 0, 0), ex(32'hABCD, 0, 0));
`else
        rd_check("no_bypass_same_cycle", 3, 3, ex(0, 1, 4), ex(0, 1, 4));
`endif
        tick();
        idle();
        rd_check("commit_next_cycle", 3, 0, ex(32'hABCD, 0, 0), ex(0, 0, 0));

        // 6a: writes to x0 are ignored
        drive_disp(0, 5);
        drive_cmt(0, 5, 32'hFFFF_FFFF);
        rd_check("x0_write_cycle", 0, 0, ex(0, 0, 0), ex(0, 0, 0));
        tick();
        idle();
        rd_check("x0_after_write", 0, 0, ex(0, 0, 0), ex(0, 0, 0));

        // 6b: reset with three renames outstanding
        drive_disp(10, 1); tick();
        drive_disp(11, 2); tick();
        drive_disp(12, 3); tick();
        idle();
        rd_check("busy_before_reset", 10, 12, ex(0, 1, 1), ex(0, 1, 3));
        rst_in = 1'b0;
        rd_check("read_during_reset", 11, 5, ex(0, 0, 0), ex(0, 0, 0));
        tick();
        rst_in = 1'b1;
        rd_check("after_reset_a", 10, 11, ex(0, 0, 0), ex(0, 0, 0));
        rd_check("after_reset_b", 12, 5, ex(0, 0, 0), ex(0, 0, 0));
        rd_check("after_reset_c", 7, 8, ex(0, 0, 0), ex(0, 0, 0));

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
